alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the team's 8-bit combinational ALU. It keeps the same 16-entry opcode map, but every result is registered and carries status flags. Multiply and divide run as iterative multi-cycle operations that return full-width results (high product half, remainder). It sits between an operand-issuing controller and a result consumer, with valid/ready flow control on both sides.

## Interface
- WIDTH, 8, operand and result width (≥ 4)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  block can accept a command this cycle
- A  input  WIDTH  operand A (unsigned unless noted)
- B  input  WIDTH  operand B
- Sel  input  4  opcode
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  consumer accepts result
- Out  output  WIDTH  primary result
- OutHi  output  WIDTH  product high half (MUL), remainder (DIV), else 0
- Carry  output  1  carry/borrow/shifted-out bit
- Zero  output  1  Out == 0
- Overflow  output  1  signed overflow / product overflow / divide-by-zero

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHL by 1, 5 SHR by 1 (logical), 6 ROL by 1, 7 ROR by 1, 8 AND, 9 OR, A XOR, B NAND, C NOR, D XNOR, E (A>B unsigned ? 1 : 0), F (A==B ? 1 : 0).
- ADD: Carry = bit WIDTH of the (WIDTH+1)-bit sum. Overflow = two's-complement signed overflow.
- SUB: Carry = borrow (A<B unsigned). Overflow = signed overflow.
- SHL: Carry = A[WIDTH-1]. SHR: Carry = A[0].
- All other single-cycle ops: Carry = 0, Overflow = 0.
- MUL: unsigned shift-add, one partial product per cycle. {OutHi,Out} = A*B. Overflow = (OutHi != 0).
- DIV: unsigned restoring division, one quotient bit per cycle. Out = A/B, OutHi = A%B.
- DIV with B = 0: skip iteration. Out = all ones, OutHi = A, Overflow = 1, Carry = 0.
- Zero is computed from Out for every opcode.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: accept on in_valid&&in_ready. Single-cycle ops and divide-by-zero go to DONE. MUL goes to MUL. DIV goes to DIV.
  - MUL/DIV: an iteration counter counts WIDTH cycles, then the state goes to DONE.
  - DONE: out_valid=1. If out_ready and no new command, go to IDLE. If out_ready and a command is accepted in the same cycle, take the IDLE transition for the new command.
- in_ready = (state==IDLE) || (state==DONE && out_ready). in_ready is forced to 0 while rst is asserted.
- Operands are captured at acceptance. A, B and Sel may change freely afterwards.

## Timing
- Reset: state IDLE, counter 0. out_valid, Out, OutHi, Carry, Zero and Overflow are all 0.
- Single-cycle op accepted in cycle N: out_valid=1 from cycle N+1. Result registers are updated in the same edge.
- MUL, or DIV with B≠0, accepted in cycle N: out_valid=1 from cycle N+WIDTH+1. in_ready=0 during cycles N+1..N+WIDTH.
- Result outputs and flags are stable while out_valid=1 && out_ready=0, for any number of cycles.
- Result handshake with simultaneous acceptance: the new result replaces the old at the next edge, with no bubble for single-cycle ops. This gives back-to-back throughput of 1 per cycle.
- Result handshake without a new command: out_valid drops at the next edge. Result registers keep their last value.
- Asynchronous reset mid-MUL/DIV aborts the operation immediately and clears everything to reset values. The first command after reset deassertion is processed normally.
- Outputs are undefined only while out_valid=0. The bench checks outputs only when out_valid=1.

## Test plan
- WIDTH=8, ADD A=0xF0 B=0x20 -> one cycle later out_valid=1, Out=0x10, Carry=1, Overflow=0, Zero=0. Then ADD 0x7F+0x01 -> Out=0x80, Carry=0, Overflow=1.
- SUB 0x05-0x07 -> Out=0xFE, Carry=1. XNOR 0xAA,0x55 -> Out=0x00, Zero=1. SHL 0x81 -> Out=0x02, Carry=1. ROR 0x01 -> Out=0x80.
- MUL 200*3 -> out_valid exactly 9 cycles after acceptance, Out=0x58, OutHi=0x02, Overflow=1. in_ready=0 during iteration.
- DIV 200/7 -> 9-cycle latency, Out=28, OutHi=4. DIV 0x33/0 -> next cycle Out=0xFF, OutHi=0x33, Overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> outputs and out_valid unchanged, in_ready=0. Then stream 4 single-cycle ops with out_ready=1 -> 4 results on 4 consecutive cycles, in order.
- Assert rst at iteration 4 of a DIV -> all outputs 0 immediately. After release, issue EQ 0x3C,0x3C -> Out=0x01 one cycle after acceptance.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked, registered ALU with status flags.
// MUL and DIV iterate one bit per cycle and return full-width results.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] OutHi,
  output logic             Carry,
  output logic             Zero,
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] outhi_q, outhi_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] sc_out, sc_hi;
  logic             sc_c, sc_v;

  always_comb begin
    sum    = {1'b0, A} + {1'b0, B};
    dif    = {1'b0, A} - {1'b0, B};
    sc_out = '0;
    sc_hi  = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    unique case (Sel)
      4'h0: begin
        sc_out = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (A[WIDTH-1] == B[WIDTH-1]) &&
                 (sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'h1: begin
        sc_out = dif[WIDTH-1:0];
        sc_c   = dif[WIDTH];
        sc_v   = (A[WIDTH-1] != B[WIDTH-1]) &&
                 (dif[WIDTH-1] != A[WIDTH-1]);
      end
      4'h2: sc_out = '0;
      // Only reached here for divide-by-zero
      4'h3: begin
        sc_out = '1;
        sc_hi  = A;
        sc_v   = 1'b1;
      end
      4'h4: begin
        sc_out = {A[WIDTH-2:0], 1'b0};
        sc_c   = A[WIDTH-1];
      end
      4'h5: begin
        sc_out = {1'b0, A[WIDTH-1:1]};
        sc_c   = A[0];
      end
      4'h6: sc_out = {A[WIDTH-2:0], A[WIDTH-1]};
      4'h7: sc_out = {A[0], A[WIDTH-1:1]};
      4'h8: sc_out = A & B;
      4'h9: sc_out = A | B;
      4'hA: sc_out = A ^ B;
      4'hB: sc_out = ~(A & B);
      4'hC: sc_out = ~(A | B);
      4'hD: sc_out = ~(A ^ B);
      4'hE: sc_out = WIDTH'(A > B);
      4'hF: sc_out = WIDTH'(A == B);
    endcase
  end

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH:0]   div_sh, div_df;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem, div_quo;

  // MUL: hi:lo holds partial product and remaining multiplier bits.
  // DIV: hi is the remainder, lo shifts dividend out and quotient in.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_sh  = {hi_q, lo_q[WIDTH-1]};
    div_df  = div_sh - {1'b0, opd_q};
    div_ok  = !div_df[WIDTH];
    div_rem = div_ok ? div_df[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_quo = {lo_q[WIDTH-2:0], div_ok};
  end

  logic accept;
  logic last_iter;

  assign in_ready  = !rst && ((state_q == S_IDLE) ||
                     ((state_q == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opd_d   = opd_q;
    out_d   = out_q;
    outhi_d = outhi_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          hi_d  = '0;
          cnt_d = '0;
          if (Sel == 4'h2) begin
            state_d = S_MUL;
            lo_d    = B;
            opd_d   = A;
          end else if ((Sel == 4'h3) && (B != '0)) begin
            state_d = S_DIV;
            lo_d    = A;
            opd_d   = B;
          end else begin
            state_d = S_DONE;
            out_d   = sc_out;
            outhi_d = sc_hi;
            carry_d = sc_c;
            zero_d  = (sc_out == '0);
            ovf_d   = sc_v;
          end
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        hi_d  = mul_hi;
        lo_d  = mul_lo;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          state_d = S_DONE;
          cnt_d   = '0;
          out_d   = mul_lo;
          outhi_d = mul_hi;
          carry_d = 1'b0;
          zero_d  = (mul_lo == '0);
          ovf_d   = (mul_hi != '0);
        end
      end
      S_DIV: begin
        hi_d  = div_rem;
        lo_d  = div_quo;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          state_d = S_DONE;
          cnt_d   = '0;
          out_d   = div_quo;
          outhi_d = div_rem;
          carry_d = 1'b0;
          zero_d  = (div_quo == '0);
          ovf_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opd_q   <= '0;
      out_q   <= '0;
      outhi_q <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opd_q   <= opd_d;
      out_q   <= out_d;
      outhi_q <= outhi_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign Out       = out_q;
  assign OutHi     = outhi_q;
  assign Carry     = carry_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed test-plan cases,
// backpressure, reset abort and randomized traffic.
module tb_alu_seq;

  localparam int    W    = 8;
  localparam longint M    = 64'd1 << W;
  localparam longint HALF = M / 2;

  typedef struct packed {
    logic [W-1:0] o;
    logic [W-1:0] h;
    logic         c;
    logic         z;
    logic         v;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] A, B;
  logic [3:0]   Sel;
  logic         out_valid, out_ready;
  logic [W-1:0] Out, OutHi;
  logic         Carry, Zero, Overflow;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Sel(Sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .Out(Out), .OutHi(OutHi),
    .Carry(Carry), .Zero(Zero), .Overflow(Overflow)
  );

  initial forever #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   rand_bp = 0;
  res_t sb[$];
  int   pops[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(input logic [3:0] s,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    res_t   r;
    longint ua, ub, t, sa, sb2, st;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = (ua >= HALF) ? ua - M : ua;
    sb2 = (ub >= HALF) ? ub - M : ub;
    r   = '0;
    case (s)
      4'h0: begin
        t = ua + ub; r.o = W'(t); r.c = (t >= M);
        st = sa + sb2; r.v = (st >= HALF) || (st < -HALF);
      end
      4'h1: begin
        t = ua - ub; r.o = W'(t); r.c = (ua < ub);
        st = sa - sb2; r.v = (st >= HALF) || (st < -HALF);
      end
      4'h2: begin
        t = ua * ub; r.o = W'(t % M); r.h = W'(t / M);
        r.v = (t >= M);
      end
      4'h3: begin
        if (ub == 0) begin
          r.o = '1; r.h = a; r.v = 1'b1;
        end else begin
          r.o = W'(ua / ub); r.h = W'(ua % ub);
        end
      end
      4'h4: begin r.o = W'(ua * 2); r.c = (ua >= HALF); end
      4'h5: begin r.o = W'(ua / 2); r.c = (ua % 2 == 1); end
      4'h6: r.o = W'(ua * 2 + ua / HALF);
      4'h7: r.o = W'(ua / 2 + (ua % 2) * HALF);
      4'h8: r.o = a & b;
      4'h9: r.o = a | b;
      4'hA: r.o = a ^ b;
      4'hB: r.o = ~(a & b);
      4'hC: r.o = ~(a | b);
      4'hD: r.o = ~(a ^ b);
      4'hE: r.o = (ua > ub) ? W'(1) : W'(0);
      default: r.o = (ua == ub) ? W'(1) : W'(0);
    endcase
    r.z = (r.o == '0);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_res(input string nm, input res_t e);
    chk({nm, "_valid"}, 64'(out_valid), 64'd1);
    chk(nm, 64'({Out, OutHi, Carry, Zero, Overflow}), 64'(e));
  endtask

  // Scoreboard monitor: a result leaves on every valid && ready cycle
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got %0h expected none",
                 {Out, OutHi, Carry, Zero, Overflow});
      end else begin
        chk("sb_result", 64'({Out, OutHi, Carry, Zero, Overflow}),
            64'(sb.pop_front()));
        pops.push_back(cyc);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rand_bp) out_ready = ($urandom % 4) != 0;
  end

  task automatic issue(input logic [3:0] s, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1; Sel = s; A = a; B = b;
    #1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_timeout: got in_ready=0 expected 1");
    end else begin
      sb.push_back(model(s, a, b));
    end
  endtask

  task automatic issue_wait(input string nm, input logic [3:0] s,
                            input logic [W-1:0] a,
                            input logic [W-1:0] b, input int lat);
    int k;
    issue(s, a, b);
    k = 0;
    do begin
      @(negedge clk);
      if (k == 0) begin
        in_valid = 1'b0;
        A = W'($urandom); B = W'($urandom); Sel = 4'($urandom);
      end
      #1;
      k++;
      if (k < lat) chk({nm, "_busy"}, 64'(in_ready), 64'd0);
    end while (!out_valid && k < 40);
    chk({nm, "_latency"}, 64'(k), 64'(lat));
  endtask

  function automatic res_t mk(input logic [W-1:0] o, input logic [W-1:0] h,
                              input logic c, input logic z, input logic v);
    res_t r;
    r = '{o: o, h: h, c: c, z: z, v: v};
    return r;
  endfunction

  initial begin
    int first;
    int guard;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Sel = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_outputs", 64'({Out, OutHi, Carry, Zero, Overflow}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    issue_wait("add_carry", 4'h0, 8'hF0, 8'h20, 1);
    chk_res("add_carry_res", mk(8'h10, 8'h00, 1, 0, 0));
    issue_wait("add_ovf", 4'h0, 8'h7F, 8'h01, 1);
    chk_res("add_ovf_res", mk(8'h80, 8'h00, 0, 0, 1));
    issue_wait("sub_borrow", 4'h1, 8'h05, 8'h07, 1);
    chk_res("sub_borrow_res", mk(8'hFE, 8'h00, 1, 0, 0));
    issue_wait("xnor_zero", 4'hD, 8'hAA, 8'h55, 1);
    chk_res("xnor_zero_res", mk(8'h00, 8'h00, 0, 1, 0));
    issue_wait("shl", 4'h4, 8'h81, 8'h00, 1);
    chk_res("shl_res", mk(8'h02, 8'h00, 1, 0, 0));
    issue_wait("ror", 4'h7, 8'h01, 8'h00, 1);
    chk_res("ror_res", mk(8'h80, 8'h00, 0, 0, 0));
    issue_wait("mul", 4'h2, 8'd200, 8'd3, W + 1);
    chk_res("mul_res", mk(8'h58, 8'h02, 0, 0, 1));
    issue_wait("div", 4'h3, 8'd200, 8'd7, W + 1);
    chk_res("div_res", mk(8'd28, 8'd4, 0, 0, 0));
    issue_wait("div0", 4'h3, 8'h33, 8'h00, 1);
    chk_res("div0_res", mk(8'hFF, 8'h33, 0, 0, 1));

    // Backpressure: result must hold while the consumer stalls
    @(negedge clk);
    out_ready = 1'b0;
    issue_wait("bp", 4'h0, 8'h12, 8'h34, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk_res("bp_hold", mk(8'h46, 8'h00, 0, 0, 0));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    pops.delete();
    out_ready = 1'b1;
    issue(4'h9, 8'h0F, 8'h30);
    issue(4'hE, 8'h40, 8'h3F);
    issue(4'h6, 8'h80, 8'h00);
    issue(4'h8, 8'hC3, 8'h0F);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("stream_count", 64'(pops.size()), 64'd5);
    if (pops.size() == 5)
      chk("stream_back_to_back", 64'(pops[4] - pops[1]), 64'd3);

    // Reset in the middle of a divide
    issue(4'h3, 8'd200, 8'd7);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("div_busy_pre_rst", 64'(out_valid), 64'd0);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    chk("abort_outputs", 64'({Out, OutHi, Carry, Zero, Overflow}), 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue_wait("eq_after_rst", 4'hF, 8'h3C, 8'h3C, 1);
    chk_res("eq_after_rst_res", mk(8'h01, 8'h00, 0, 0, 0));

    // Randomized traffic with random consumer stalls
    rand_bp = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 3 == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
      end else begin
        logic [W-1:0] ra, rb;
        ra = W'($urandom);
        rb = W'($urandom);
        if ($urandom % 8 == 0) rb = '0;
        if ($urandom % 8 == 0) ra = '1;
        issue(4'($urandom), ra, rb);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    rand_bp = 0;
    out_ready = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    first = sb.size();
    chk("drain_empty", 64'(first), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
